// File: rtl/mips_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mips_dmem_responder
// Purpose  : Data-memory responder for the MIPS load/store port. Accepts one
//            word request at a time, inserts WAIT_CYCLES wait states, then
//            commits a byte-enabled store or returns a little-endian load word
//            (byte addr+0 on bits 7:0). Out-of-range accesses return an error.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous reset, active low
//            req_valid/req_ready/req_write/req_addr/req_wdata/req_be
//                       - request channel
//            rsp_valid/rsp_ready/rsp_rdata/rsp_err
//                       - response channel
// Options  : DMEM_ALIGN_CHECK_EN - when defined, a non-word-aligned address
//            completes with rsp_err=1 and no array access.
// Revision : 1.0 - initial release
// ============================================================================
module mips_dmem_responder #(
    parameter int DEPTH_BYTES = 128,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [7:0]  mem [DEPTH_BYTES];

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_op_write;
    logic [31:0]   w_op_addr;
    logic [31:0]   w_op_wdata;
    logic [3:0]    w_op_be;
    logic          w_in_range;
    logic          w_ok;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_load_word;

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    assign w_accept = req_valid && req_ready;

    // With zero wait states the commit happens on the accept edge itself, so
    // the operation must be taken straight from the request inputs.
    assign w_op_write = (state_q == S_IDLE) ? req_write : write_q;
    assign w_op_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign w_op_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign w_op_be    = (state_q == S_IDLE) ? req_be    : be_q;

    // Qualified by rst so no commit can slip through while reset is held.
    assign w_enter_resp = rst &&
        (((state_q == S_IDLE) && w_accept && (WAIT_CYCLES == 0)) ||
         ((state_q == S_WAIT) && (cnt_q == 4'd0)));

    // 33-bit sum: addr+3 must not wrap, and this also forces upper bits to 0.
    assign w_in_range = ({1'b0, w_op_addr} + 33'd3) < 33'(DEPTH_BYTES);

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_ok = w_in_range && (w_op_addr[1:0] == 2'b00);
`else
    assign w_ok = w_in_range;
`endif

    assign w_idx = w_op_addr[AW-1:0];

    // Byte-wise read so unaligned in-range loads work; w_ok guarantees no wrap.
    always_comb begin
        w_load_word = 32'd0;
        for (int i = 0; i < 4; i++) begin
            w_load_word[8*i +: 8] = mem[w_idx + AW'(i)];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (w_enter_resp) begin
                rdata_q <= (w_ok && !w_op_write) ? w_load_word : 32'd0;
                err_q   <= !w_ok;
            end
        end
    end

    // Array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_enter_resp && w_ok && w_op_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_op_be[i]) begin
                    mem[w_idx + AW'(i)] <= w_op_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mips_dmem_responder.md
Name: mips_dmem_responder

Overview:
Data-memory responder on the MIPS load/store port. It is the memory end of the CPU's data-access interface.
- Accepts one word request at a time from the CPU, with a valid/ready handshake.
- Inserts a configurable number of wait states.
- Commits stores using byte enables, or returns load data.
- Signals an error for out-of-range accesses.
- Byte-addressable little-endian array: byte at addr+0 maps to data bits 7:0 and byte at addr+3 to bits 31:24, matching the CPU's fetch byte order.

Parameters:
- DEPTH_BYTES, 128, size of the byte array; must be a power of 2 and at least 4.
- WAIT_CYCLES, 1, wait states between request acceptance and response (0..15).

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = in reset).
- req_valid  in  1  the CPU presents a request.
- req_ready  out  1  the responder can accept a request.
- req_write  in  1  1 = store (sw), 0 = load (lw).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  store byte enables; bit i writes byte addr+i.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  the CPU takes the response.
- rsp_rdata  out  32  load data; 0 for stores and on error.
- rsp_err  out  1  the access failed (range, or alignment when enabled).

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch addr, wdata, be and write.
  - Go to WAIT if WAIT_CYCLES>0, else to RESP.
- WAIT:
  - req_ready=0.
  - A 4-bit counter loads WAIT_CYCLES-1 on acceptance and decrements each cycle.
  - Go to RESP on the edge where the counter equals 0.
- Commit and latency:
  - The store commit and the load capture happen on the edge that enters RESP.
  - rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accept edge.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_err are registered and stay stable until rsp_valid&&rsp_ready.
  - The handshake edge returns the FSM to IDLE.
  - Back-pressure: rsp_ready held low keeps the FSM in RESP indefinitely.
- Throughput: at most one transaction per WAIT_CYCLES+2 cycles. req_ready is never 1 while rsp_valid=1.
- Range check:
  - An access is valid only if req_addr+3 < DEPTH_BYTES, with no 32-bit wrap.
  - Upper address bits above log2(DEPTH_BYTES) must be 0.
  - A failing access gives rsp_err=1 and rsp_rdata=0, and the array is unchanged.
- Stores:
  - Only bytes with be[i]=1 are written.
  - be=0000 is legal: no change, rsp_err=0.
  - rsp_rdata=0.
- Loads:
  - Return all 4 bytes regardless of req_be.
  - An unaligned in-range load is allowed when the alignment check is compiled out.
- Request inputs are ignored outside IDLE and have no side effects.
- Reset:
  - Async assert forces IDLE and clears the counter.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=1 from the first cycle after deassertion.
  - The byte array is not reset; contents are undefined until written.
  - Reset mid-WAIT drops the transaction: a store not yet committed leaves the array unchanged.
  - Reset during RESP drops the response.
- Simultaneous events: the RESP handshake and a new req_valid in the same cycle are not accepted together. The new request is accepted in the following IDLE cycle.

Optional Feature:
DMEM_ALIGN_CHECK_EN
- Defined: a request with req_addr[1:0]!=0 completes with rsp_err=1, rsp_rdata=0 and no array write. The timing is identical to a normal access.
- Undefined: no alignment check; an unaligned in-range access is performed byte-wise at addr..addr+3.

Test Plan:
1. Store then load, with WAIT_CYCLES=1:
   - sw addr=0x10, wdata=0xDEADBEEF, be=1111 gives rsp_valid exactly 2 cycles after accept, rsp_err=0.
   - A following lw 0x10 returns 0xDEADBEEF; byte 0x10 holds 0xEF.
2. Partial store:
   - With 0x11223344 at 0x20, sw 0x20 wdata=0xAABBCCDD be=0101.
   - lw 0x20 then returns 0x11BB33DD.
3. Out of range with DEPTH_BYTES=128:
   - lw 0x7D gives rsp_err=1, rsp_rdata=0.
   - sw 0x80 gives rsp_err=1, and the array checksum is unchanged.
4. Back-pressure:
   - Hold rsp_ready=0 for 5 cycles after a lw 0x10 response.
   - rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0.
   - After the handshake, req_ready=1 on the next cycle.
5. Reset mid-operation, with WAIT_CYCLES=3:
   - Issue sw 0x30 wdata=0x12345678, then drop rst to 0 during WAIT.
   - Outputs reset immediately, without waiting for clk.
   - lw 0x30 afterwards returns the value held before the store.
6. Alignment:
   - With DMEM_ALIGN_CHECK_EN defined, lw 0x12 gives rsp_err=1.
   - Without it, lw 0x12 gives bytes 0x12..0x15 and rsp_err=0.
   - With WAIT_CYCLES=0, rsp_valid comes 1 cycle after accept.
